// File: rtl/trigger_sequencer.sv
// Acquisition sequencer: arm, wait for a trigger, skip a programmable number of
// samples, then mark a programmable number of samples for capture.
module trigger_sequencer #(
   parameter int CNT_W  = 16,
   parameter int MISS_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              abort,
   input  logic              auto_rearm,
   input  logic              trig_in,
   input  logic              sample_valid,
   input  logic [CNT_W-1:0]  delay_cfg,
   input  logic [CNT_W-1:0]  len_cfg,
   output logic              capture_en,
   output logic [CNT_W-1:0]  sample_idx,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_o,
   output logic [MISS_W-1:0] missed
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARMED   = 3'd1;
   localparam logic [2:0] DELAY   = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  delayCnt_q, delayCnt_d;
   logic [CNT_W-1:0]  capCnt_q, capCnt_d;
   logic [CNT_W-1:0]  delayLat_q, delayLat_d;
   logic [CNT_W-1:0]  lenLat_q, lenLat_d;
   logic [MISS_W-1:0] missed_q, missed_d;

   logic              lenZero;
   logic [CNT_W-1:0]  lastDelay;
   logic [CNT_W-1:0]  lastLen;
   logic              trigIgnored;

   // Terminal values are only consulted while the matching latch is non-zero,
   // so the subtraction never wraps in practice.
   assign lenZero     = (lenLat_q == '0);
   assign lastDelay   = delayLat_q - CNT_W'(1);
   assign lastLen     = lenLat_q - CNT_W'(1);
   assign trigIgnored = trig_in && ((state_q == DELAY) || (state_q == CAPTURE) || (state_q == DONE));

   always_comb begin
      state_d    = state_q;
      delayCnt_d = delayCnt_q;
      capCnt_d   = capCnt_q;
      delayLat_d = delayLat_q;
      lenLat_d   = lenLat_q;
      missed_d   = missed_q;

      if (abort) begin
         state_d    = IDLE;
         delayCnt_d = '0;
         capCnt_d   = '0;
      end else begin
         if (trigIgnored && !(&missed_q)) begin
            missed_d = missed_q + MISS_W'(1);
         end
         case (state_q)
            IDLE: begin
               if (arm) begin
                  delayLat_d = delay_cfg;
                  lenLat_d   = len_cfg;
                  missed_d   = '0;
                  state_d    = ARMED;
               end
            end
            ARMED: begin
               if (trig_in) begin
                  delayCnt_d = '0;
                  capCnt_d   = '0;
                  if (delayLat_q != '0) begin
                     state_d = DELAY;
                  end else if (lenZero) begin
                     state_d = DONE;
                  end else begin
                     state_d = CAPTURE;
                  end
               end
            end
            DELAY: begin
               if (sample_valid) begin
                  delayCnt_d = delayCnt_q + CNT_W'(1);
                  if (delayCnt_q == lastDelay) begin
                     state_d = lenZero ? DONE : CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               // The final index is held through DONE rather than stepping past len-1.
               if (sample_valid) begin
                  if (capCnt_q == lastLen) begin
                     state_d = DONE;
                  end else begin
                     capCnt_d = capCnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               delayCnt_d = '0;
               capCnt_d   = '0;
               state_d    = auto_rearm ? ARMED : IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         delayCnt_q <= '0;
         capCnt_q   <= '0;
         delayLat_q <= '0;
         lenLat_q   <= '0;
         missed_q   <= '0;
      end else begin
         state_q    <= state_d;
         delayCnt_q <= delayCnt_d;
         capCnt_q   <= capCnt_d;
         delayLat_q <= delayLat_d;
         lenLat_q   <= lenLat_d;
         missed_q   <= missed_d;
      end
   end

   assign capture_en = (state_q == CAPTURE) && sample_valid;
   assign sample_idx = capCnt_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign state_o    = state_q;
   assign missed     = missed_q;

endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the delay and capture-length counters.
REQ-002 SHALL have parameter MISS_W, default 8, giving the width of the missed-trigger counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port arm, input, 1 bit: a one-cycle request to start an acquisition.
REQ-006 SHALL have port abort, input, 1 bit: forces return to IDLE.
REQ-007 SHALL have port auto_rearm, input, 1 bit: when 1, the block goes DONE -> ARMED instead of DONE -> IDLE.
REQ-008 SHALL have port trig_in, input, 1 bit: the one-cycle trigger pulse from the edge-trigger block.
REQ-009 SHALL have port sample_valid, input, 1 bit: ADC sample strobe.
REQ-010 SHALL have port delay_cfg, input, CNT_W bits: post-trigger delay, in valid samples.
REQ-011 SHALL have port len_cfg, input, CNT_W bits: capture length, in valid samples.
REQ-012 SHALL have port capture_en, output, 1 bit: marks a sample to store.
REQ-013 SHALL have port sample_idx, output, CNT_W bits: index of the current captured sample.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port state_o, output, 3 bits: state encoding for status readback.
REQ-017 SHALL have port missed, output, MISS_W bits: count of triggers ignored.

Function
REQ-018 SHALL implement states IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4 and present them on state_o, driven directly from the state register.
REQ-019 SHALL, in IDLE with arm=1, latch delay_cfg and len_cfg into internal registers, clear missed, and enter ARMED on the next cycle.
REQ-020 SHALL ignore arm in every state other than IDLE.
REQ-021 SHALL ignore trig_in in the same cycle that arm is accepted.
REQ-022 SHALL, in ARMED with trig_in=1, enter DELAY when the latched delay is non-zero, otherwise enter CAPTURE, with zero counters in either case.
REQ-023 SHALL, in DELAY, increment the delay counter on each sample_valid and enter CAPTURE on the cycle after the sample_valid that brings the count to the latched delay.
REQ-024 SHALL drive capture_en = (state==CAPTURE) & sample_valid, which is combinational from registered state.
REQ-025 SHALL drive sample_idx from the capture counter, which starts at 0 and increments on each capture_en.
REQ-026 SHALL, in CAPTURE, enter DONE on the cycle after capture_en with sample_idx == len-1.
REQ-027 SHALL, when the latched len is 0, go ARMED -> (DELAY ->) DONE and never assert capture_en.
REQ-028 SHALL stay in DONE for exactly one cycle, with done=1 only in DONE.
REQ-029 SHALL leave DONE for ARMED when auto_rearm=1, keeping the latched configuration and missed unchanged, and for IDLE otherwise.
REQ-030 SHALL increment missed, saturating at all-ones, on each trig_in during DELAY, CAPTURE or DONE.
REQ-031 SHALL, on abort=1 in any state, enter IDLE on the next cycle, clear both counters, and produce no done pulse.
REQ-032 SHALL give abort priority over arm, trig_in and sample_valid when they occur in the same cycle.
REQ-033 SHALL treat latched delay and len as unsigned; counter comparisons use the full CNT_W bits and never wrap.

Reset
REQ-034 SHALL, while reset=0, asynchronously force: state IDLE, both counters 0, latched configuration 0, missed 0, capture_en 0, sample_idx 0, busy 0, done 0, state_o 0.
REQ-035 SHALL, when reset is asserted mid-capture, abandon the acquisition with no done pulse, and SHALL be in IDLE on the first clock edge after reset deasserts.

Verification
REQ-036 SHALL pass a basic capture test: delay_cfg=2, len_cfg=4, arm, trig_in, sample_valid every cycle -> two DELAY samples, then capture_en for exactly 4 cycles with sample_idx 0..3, then done for 1 cycle, then IDLE with busy=0.
REQ-037 SHALL pass a zero-parameter test: delay_cfg=0, len_cfg=0, arm, trig_in -> ARMED -> DONE with no DELAY and no capture_en, and done asserted once.
REQ-038 SHALL pass a missed-trigger test: 3 trig_in pulses during CAPTURE -> missed=3; 300 pulses with MISS_W=8 -> missed=255; a new arm from IDLE -> missed=0.
REQ-039 SHALL pass an auto-rearm test: auto_rearm=1, len_cfg=2 -> after done, state_o=1 (ARMED) the next cycle, and a second trig_in yields a second 2-sample capture.
REQ-040 SHALL pass an abort/arm collision test: abort and arm in the same cycle while in CAPTURE at sample_idx=1 -> IDLE the next cycle, sample_idx=0, no done pulse.
REQ-041 SHALL pass a reset-mid-operation test: reset=0 mid-DELAY, asynchronous to clk -> all outputs 0 immediately; a subsequent trig_in with no arm is ignored.
